// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// LSU_MISALIGN_CHECK_EN (optional build macro) enables misaligned-access faulting in lsu.
package lsu_pkg;

    localparam int unsigned MEM_LATENCY_DEFAULT = 1;
    localparam int unsigned CNT_W               = 4;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;
    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Unsigned codes only exist for loads; a store with 100/101 is a word store.
    function automatic size_e access_size(input logic is_store, input logic [2:0] funct3);
        case (funct3)
            LB:      return SzByte;
            LH:      return SzHalf;
            LW:      return SzWord;
            LBU:     return is_store ? SzWord : SzByte;
            LHU:     return is_store ? SzWord : SzHalf;
            default: return SzWord;
        endcase
    endfunction

    function automatic logic misaligned(input logic is_store, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
        case (access_size(is_store, funct3))
            SzHalf:  return addr_lo[0];
            SzWord:  return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte mask, store data shift, load extract and extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    size_e       size;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic        sign_en;

    always_comb begin
        size     = access_size(is_store, funct3);
        shamt    = {addr_lo, 3'b000};
        sign_en  = ~funct3[2];
        wdata_sh = wdata << shamt;
        shifted  = rword >> shamt;
        // Lanes shifted past byte 3 fall off the 4-bit mask.
        unique case (size)
            SzByte: begin
                wmask     = 4'b0001 << addr_lo;
                rdata_ext = {{24{sign_en & shifted[7]}}, shifted[7:0]};
            end
            SzHalf: begin
                wmask     = 4'b0011 << addr_lo;
                rdata_ext = {{16{sign_en & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                wmask     = 4'b1111 << addr_lo;
                rdata_ext = shifted;
            end
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Single-outstanding load/store unit with emulated memory latency.
// LSU_MISALIGN_CHECK_EN: when defined, misaligned accesses fault without touching memory.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_ren,
    input  logic        in_wen,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [2:0]  in_funct3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_fault,
    output logic        mem_valid,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_wen,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask
);

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MEM_LATENCY > 1 ? MEM_LATENCY - 2 : 0);

    state_e           state_q, state_d;
    logic             load_q, store_q, fault_q;
    logic [31:0]      addr_q, wdata_q, rword_q;
    logic [2:0]       funct3_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_fault, in_noop;
    logic [3:0]       lane_mask;
    logic [31:0]      wdata_sh, rdata_ext;

    assign in_noop = ~in_ren & ~in_wen;
`ifdef LSU_MISALIGN_CHECK_EN
    assign in_fault = ~in_noop & misaligned(in_wen, in_funct3, in_addr[1:0]);
`else
    assign in_fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = (in_noop || in_fault) ? StResp : StIssue;
            StIssue: state_d = (MEM_LATENCY == 1) ? StResp : StWait;
            StWait:  if (cnt_q == '0) state_d = StResp;
            StResp:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request register; store wins when both ren and wen are set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_q   <= 1'b0;
            store_q  <= 1'b0;
            fault_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            rword_q  <= '0;
            cnt_q    <= '0;
        end else begin
            if (state_q == StIdle && in_valid) begin
                load_q   <= in_ren & ~in_wen;
                store_q  <= in_wen;
                fault_q  <= in_fault;
                addr_q   <= in_addr;
                wdata_q  <= in_wdata;
                funct3_q <= in_funct3;
            end
            if (state_q == StIssue) begin
                if (load_q) rword_q <= mem_rdata;
                cnt_q <= CntLoad;
            end
            if (state_q == StWait && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        end
    end

    lsu_align u_align (
        .funct3    (funct3_q),
        .is_store  (store_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rword     (rword_q),
        .wmask     (lane_mask),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext)
    );

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StResp);
        out_fault = (state_q == StResp) & fault_q;
        out_rdata = (state_q == StResp && load_q && !fault_q) ? rdata_ext : 32'h0;
        mem_valid = (state_q == StIssue);
        mem_wen   = (state_q == StIssue) & store_q;
        mem_raddr = (state_q == StIssue) ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_waddr = mem_raddr;
        mem_wdata = mem_wen ? wdata_sh : 32'h0;
        mem_wmask = mem_wen ? {4'b0000, lane_mask} : 8'h00;
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, corner sequences and random traffic
// against a byte-addressed reference model.
module tb_lsu;

    localparam int unsigned LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_ren, in_wen;
    logic [31:0] in_addr, in_wdata;
    logic [2:0]  in_funct3;
    logic        out_valid, out_ready, out_fault;
    logic [31:0] out_rdata;
    logic        mem_valid, mem_wen;
    logic [31:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
    logic [7:0]  mem_wmask;

    logic        in_valid_1, in_ready_1, out_valid_1, out_ready_1, out_fault_1;
    logic [31:0] out_rdata_1;
    logic        mem_valid_1, mem_wen_1;
    logic [31:0] mem_raddr_1, mem_rdata_1, mem_waddr_1, mem_wdata_1;
    logic [7:0]  mem_wmask_1;

    logic [31:0] mem [16];
    logic [7:0]  ref_mem [64];
    logic        preload;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    lsu #(.MEM_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren),
        .in_wen(in_wen), .in_addr(in_addr), .in_wdata(in_wdata), .in_funct3(in_funct3),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_fault(out_fault), .mem_valid(mem_valid), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
    );

    lsu #(.MEM_LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1), .in_ren(in_ren),
        .in_wen(in_wen), .in_addr(in_addr), .in_wdata(in_wdata), .in_funct3(in_funct3),
        .out_valid(out_valid_1), .out_ready(out_ready_1), .out_rdata(out_rdata_1),
        .out_fault(out_fault_1), .mem_valid(mem_valid_1), .mem_raddr(mem_raddr_1),
        .mem_rdata(mem_rdata_1), .mem_wen(mem_wen_1), .mem_waddr(mem_waddr_1),
        .mem_wdata(mem_wdata_1), .mem_wmask(mem_wmask_1)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'hDEAD_BEEF;
        if (i == 1) return 32'h12F4_5678;
        return 32'(32'h9E37_79B9 * (i + 1));
    endfunction

    // Physical memory: combinational read, masked write on the clock.
    assign mem_rdata   = mem[mem_raddr[5:2]];
    assign mem_rdata_1 = mem[mem_raddr_1[5:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
        end else if (mem_wen) begin
            for (int l = 0; l < 4; l++)
                if (mem_wmask[l]) mem[mem_waddr[5:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic int op_size(input logic st, input logic [2:0] f3);
        if (f3 == 3'b000) return 1;
        if (f3 == 3'b001) return 2;
        if (!st && f3 == 3'b100) return 1;
        if (!st && f3 == 3'b101) return 2;
        return 4;
    endfunction

    // One full transaction on the latency-LAT unit, checked against the byte-level model.
    task automatic run(input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                       output logic [31:0] got_rdata, output logic [31:0] got_mask,
                       output logic [31:0] got_wdata);
        logic        st, ld, noop, mis, fault, got_wen;
        int          n, off, base, exp_lat, exp_strobes, cyc, strobes;
        logic [31:0] exp_rdata, exp_mask, exp_wdata, got_raddr, got_waddr;
        st = wen;
        ld = ren & ~wen;
        noop = !ren && !wen;
        n = op_size(st, f3);
        off = int'(addr[1:0]);
        base = int'(addr[5:0]) - off;
        mis = (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
        fault = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        fault = !noop && mis;
`endif
        exp_rdata = 0;
        exp_mask = 0;
        exp_wdata = 0;
        if (!noop && !fault) begin
            for (int i = 0; i < n; i++) begin
                if (off + i < 4) begin
                    if (ld) exp_rdata |= 32'(ref_mem[base + off + i]) << (8 * i);
                    if (st) begin
                        exp_mask[off + i] = 1'b1;
                        ref_mem[base + off + i] = wdata[8*i +: 8];
                    end
                end
            end
            if (ld && (f3 == 3'b000 || f3 == 3'b001) && exp_rdata[8*n-1])
                exp_rdata |= ~((32'd1 << (8 * n)) - 32'd1);
            if (st) exp_wdata = wdata << (8 * off);
        end
        exp_lat = (noop || fault) ? 1 : int'(LAT) + 1;
        exp_strobes = (noop || fault) ? 0 : 1;

        @(negedge clk);
        chk("in_ready idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_ren = ren; in_wen = wen; in_funct3 = f3;
        in_addr = addr; in_wdata = wdata; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; in_ren = 1'($urandom); in_wen = 1'($urandom);
        in_addr = $urandom; in_wdata = $urandom; in_funct3 = 3'($urandom);
        cyc = 1; strobes = 0; got_wen = 0;
        got_mask = 0; got_wdata = 0; got_raddr = 0; got_waddr = 0;
        while (!out_valid && cyc < 40) begin
            chk("in_ready busy", 32'(in_ready), 32'd0);
            if (mem_valid) begin
                strobes++;
                got_raddr = mem_raddr; got_waddr = mem_waddr; got_wen = mem_wen;
                got_mask = 32'(mem_wmask); got_wdata = mem_wdata;
            end
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("strobe count", 32'(strobes), 32'(exp_strobes));
        if (exp_strobes == 1) begin
            chk("mem_raddr", got_raddr, addr & ~32'd3);
            chk("mem_waddr", got_waddr, addr & ~32'd3);
            chk("mem_wen", 32'(got_wen), 32'(st));
        end
        chk("mem_wmask", got_mask, exp_mask);
        chk("mem_wdata", got_wdata, exp_wdata);
        for (int s = 0; s < stall; s++) begin
            chk("held out_valid", 32'(out_valid), 32'd1);
            chk("held out_rdata", out_rdata, exp_rdata);
            chk("held in_ready", 32'(in_ready), 32'd0);
            chk("held mem_valid", 32'(mem_valid), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_rdata", out_rdata, exp_rdata);
        chk("out_fault", 32'(out_fault), 32'(fault));
        got_rdata = out_rdata;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid after handshake", 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        logic        ren;
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stall;
        logic [31:0] exp_rdata;
        logic [31:0] exp_mask;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t        vecs[14];
    logic [31:0] r, m, w;
    int          sel;
    logic        rr, ww;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h8000_0000, 32'h0, 0, 32'hDEAD_BEEF, 32'h0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h8000_0006, 32'h0, 1, 32'hFFFF_FFF4, 32'h0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h8000_0006, 32'h0, 0, 32'h0000_00F4, 32'h0, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h8000_0006, 32'h0, 0, 32'h0000_12F4, 32'h0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h8000_0006, 32'h0, 0, 32'h0000_12F4, 32'h0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h8000_0000, 32'h0, 0, 32'hFFFF_BEEF, 32'h0, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'hAB, 0, 32'h0, 32'h08, 32'hAB00_0000};
        vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h1234, 0, 32'h0, 32'h0C, 32'h1234_0000};
        vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h8000_0000, 32'h0, 3, 32'h1234_BEEF, 32'h0, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 32'h0};
        vecs[10] = '{1'b1, 1'b1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 0, 32'h0, 32'h0F,
                     32'hCAFE_F00D};
        vecs[11] = '{1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0, 0, 32'hCAFE_F00D, 32'h0, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 3'b110, 32'h8000_0008, 32'h0, 0, 32'hCAFE_F00D, 32'h0, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 0, 32'h0000_0012, 32'h0, 32'h0};

        for (int i = 0; i < 16; i++) begin
            logic [31:0] wv;
            wv = init_word(i);
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = wv[8*b +: 8];
        end
        rst = 1'b1; preload = 1'b1;
        in_valid = 0; in_ren = 0; in_wen = 0; in_addr = 0; in_wdata = 0; in_funct3 = 0;
        out_ready = 0; in_valid_1 = 0; out_ready_1 = 0;
        repeat (2) @(negedge clk);

        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_rdata", out_rdata, 32'd0);
        chk("reset out_fault", 32'(out_fault), 32'd0);
        chk("reset mem_valid", 32'(mem_valid), 32'd0);
        chk("reset mem_wen", 32'(mem_wen), 32'd0);
        chk("reset mem_wmask", 32'(mem_wmask), 32'd0);
        chk("reset mem_raddr", mem_raddr, 32'd0);
        chk("reset mem_waddr", mem_waddr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0; preload = 1'b0;

        // Latency-1 word load: one strobe cycle, result two cycles after accept.
        @(negedge clk);
        in_ren = 1; in_wen = 0; in_addr = 32'h8000_0000; in_funct3 = 3'b010; in_valid_1 = 1;
        chk("l1 in_ready", 32'(in_ready_1), 32'd1);
        @(negedge clk);
        in_valid_1 = 0;
        chk("l1 issue mem_valid", 32'(mem_valid_1), 32'd1);
        chk("l1 issue mem_raddr", mem_raddr_1, 32'h8000_0000);
        chk("l1 issue out_valid", 32'(out_valid_1), 32'd0);
        @(negedge clk);
        chk("l1 resp out_valid", 32'(out_valid_1), 32'd1);
        chk("l1 resp out_rdata", out_rdata_1, 32'hDEAD_BEEF);
        chk("l1 resp mem_valid", 32'(mem_valid_1), 32'd0);
        out_ready_1 = 1;
        @(negedge clk);
        out_ready_1 = 0;
        chk("l1 idle out_valid", 32'(out_valid_1), 32'd0);
        chk("l1 idle in_ready", 32'(in_ready_1), 32'd1);

        for (int i = 0; i < 14; i++) begin
            run(vecs[i].ren, vecs[i].wen, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                vecs[i].stall, r, m, w);
            chk($sformatf("vec%0d rdata", i), r, vecs[i].exp_rdata);
            chk($sformatf("vec%0d wmask", i), m, vecs[i].exp_mask);
            chk($sformatf("vec%0d wdata", i), w, vecs[i].exp_wdata);
        end

        // Misaligned word load: faults with the macro, shifted-lane result without it.
        run(1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0, 0, r, m, w);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("misalign lw rdata", r, 32'h0);
`else
        chk("misalign lw rdata", r, 32'h0000_1234);
`endif
        run(1'b0, 1'b1, 3'b010, 32'h8000_0005, 32'h1122_3344, 0, r, m, w);

        // Reset while waiting on memory.
        @(negedge clk);
        in_valid = 1; in_ren = 1; in_wen = 0; in_addr = 32'h8000_0004; in_funct3 = 3'b010;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        chk("wait mem_valid", 32'(mem_valid), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk("post-rst mem_valid", 32'(mem_valid), 32'd0);
            chk("post-rst mem_wen", 32'(mem_wen), 32'd0);
            chk("post-rst out_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end

        for (int k = 0; k < 200; k++) begin
            sel = $urandom_range(0, 9);
            rr = (sel == 1) || (sel >= 6);
            ww = (sel >= 1) && (sel <= 5);
            run(rr, ww, 3'($urandom), 32'h8000_0000 | 32'($urandom_range(0, 63)), $urandom,
                $urandom_range(0, 2), r, m, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
